// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD unit: FSM state type and its encoding width.
package gcd_pkg;

   // Width of the FSM state encoding.
   localparam int STATE_W = 2;

   // Three-state control: waiting for operands, iterating, holding a result.
   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } gcd_state_t;

endpackage

// File: rtl/gcd_dp.sv
// GCD datapath: X/Y operand registers, load muxes, comparator and the two
// subtractors. Each step subtracts the smaller operand from the larger one, so
// the difference can never wrap.
module gcd_dp
   import gcd_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_step,
   input  logic [WIDTH-1:0] i_x,
   input  logic [WIDTH-1:0] i_y,
   output logic             o_finish,
   output logic [WIDTH-1:0] o_result
);

   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic             w_x_zero;
   logic             w_y_zero;
   logic             w_equal;
   logic             w_x_lt_y;
   logic [WIDTH-1:0] w_x_minus_y;
   logic [WIDTH-1:0] w_y_minus_x;

   assign w_x_zero    = (r_x == {WIDTH{1'b0}});
   assign w_y_zero    = (r_y == {WIDTH{1'b0}});
   assign w_equal     = (r_x == r_y);
   assign w_x_lt_y    = (r_x < r_y);
   assign w_x_minus_y = r_x - r_y;
   assign w_y_minus_x = r_y - r_x;

   // A zero operand or equal operands end the iteration; the result is the
   // non-zero operand (or Y when X is zero, which also covers gcd(0,0)=0).
   assign o_finish = w_x_zero | w_y_zero | w_equal;
   assign o_result = w_x_zero ? r_y : r_x;

   // Operand registers: load a new pair, or take one subtraction step.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_x <= {WIDTH{1'b0}};
         r_y <= {WIDTH{1'b0}};
      end else if (i_load) begin
         r_x <= i_x;
         r_y <= i_y;
      end else if (i_step && !o_finish) begin
         if (w_x_lt_y) begin
            r_y <= w_y_minus_x;
         end else begin
            r_x <= w_x_minus_y;
         end
      end
   end

endmodule

// File: rtl/gcd_unit.sv
// GCD unit top: ready/valid handshake and IDLE/CALC/DONE control around the
// gcd_dp datapath. Optional build macro GCD_UNIT_CYCLE_COUNT_EN adds the
// 'cycles' output reporting CALC cycles spent on the current/last result.
module gcd_unit
   import gcd_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] y_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef GCD_UNIT_CYCLE_COUNT_EN
   ,
   output logic [WIDTH-1:0] cycles
`endif
);

   gcd_state_t       r_state;
   gcd_state_t       w_next;
   logic             w_load;
   logic             w_step;
   logic             w_capture;
   logic             w_finish;
   logic [WIDTH-1:0] w_result;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;

   gcd_dp #(
      .WIDTH (WIDTH)
   ) u_dp (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_load),
      .i_step   (w_step),
      .i_x      (x_in),
      .i_y      (y_in),
      .o_finish (w_finish),
      .o_result (w_result)
   );

   // Next-state and datapath control decode.
   always_comb begin
      w_next    = r_state;
      w_load    = 1'b0;
      w_step    = 1'b0;
      w_capture = 1'b0;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_next = CALC;
               w_load = 1'b1;
            end else begin
               w_next = IDLE;
            end
         end
         CALC: begin
            w_step = 1'b1;
            if (w_finish) begin
               w_next    = DONE;
               w_capture = 1'b1;
            end else begin
               w_next = CALC;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_next = IDLE;
            end else begin
               w_next = DONE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // State register with handshake flags registered from the next state and
   // the result captured on the finishing CALC step.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= {WIDTH{1'b0}};
      end else begin
         r_state     <= w_next;
         r_in_ready  <= (w_next == IDLE);
         r_out_valid <= (w_next == DONE);
         if (w_capture) begin
            r_out_data <= w_result;
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

`ifdef GCD_UNIT_CYCLE_COUNT_EN
   localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_cycles;

   // CALC cycle counter: cleared on acceptance, saturates at all-ones.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cycles <= {WIDTH{1'b0}};
      end else if (w_load) begin
         r_cycles <= {WIDTH{1'b0}};
      end else if ((r_state == CALC) && (r_cycles != {WIDTH{1'b1}})) begin
         r_cycles <= r_cycles + CNT_ONE;
      end
   end

   assign cycles = r_cycles;
`endif

endmodule

// File: tb/tb_gcd_unit.sv
// Directed self-checking bench for gcd_unit (WIDTH=8) with hand-computed
// results and latencies.
module tb_gcd_unit;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] x_in = '0;
   logic [W-1:0] y_in = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
`ifdef GCD_UNIT_CYCLE_COUNT_EN
   logic [W-1:0] cycles;
`endif

   int           n_total = 0;
   int           n_pass  = 0;
   logic [W-1:0] last_res = '0;
   int           lat;

   gcd_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .y_in      (y_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef GCD_UNIT_CYCLE_COUNT_EN
      ,
      .cycles    (cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until out_valid, bounded so a stuck DUT cannot hang the run.
   task automatic wait_valid(output int n);
      n = 0;
      while (out_valid !== 1'b1 && n < 600) begin
         tick();
         n++;
      end
   endtask

   task automatic check_cycles(input string tag, input logic [W-1:0] exp);
`ifdef GCD_UNIT_CYCLE_COUNT_EN
      check(tag, {24'd0, cycles}, {24'd0, exp});
`endif
   endtask

   // Offers a pair in IDLE, then checks latency, result and counter in DONE.
   task automatic run_pair(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] res, input int lat_exp, input string tag);
      int n;
      x_in = x;
      y_in = y;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
      check({tag, "_retain"}, {24'd0, out_data}, {24'd0, last_res});
      wait_valid(n);
      check({tag, "_latency"}, n, lat_exp);
      check({tag, "_data"}, {24'd0, out_data}, {24'd0, res});
      check_cycles({tag, "_cycles"}, W'(lat_exp));
      last_res = res;
   endtask

   task automatic release_result(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
      check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      // Reset state
      rst = 1'b0;
      tick();
      tick();
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      check_cycles("rst_cycles", 8'd0);
      rst = 1'b1;
      tick();

      // Basic pair and zero-operand cases
      run_pair(8'd12, 8'd8, 8'd4, 3, "p12_8");
      release_result("p12_8");
      run_pair(8'd0, 8'd9, 8'd9, 1, "p0_9");
      release_result("p0_9");
      run_pair(8'd0, 8'd0, 8'd0, 1, "p0_0");
      release_result("p0_0");
      run_pair(8'd9, 8'd0, 8'd9, 1, "p9_0");
      release_result("p9_0");

      // Result held stable while the consumer stalls
      run_pair(8'd21, 8'd14, 8'd7, 3, "p21_14");
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", {31'd0, out_valid}, 32'd1);
         check("stall_data", {24'd0, out_data}, 32'd7);
         check("stall_in_ready", {31'd0, in_ready}, 32'd0);
         tick();
      end
      release_result("p21_14");

      // Reset in the middle of a long computation
      x_in = 8'd100;
      y_in = 8'd3;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      check("midcalc_busy", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_out_data", {24'd0, out_data}, 32'd0);
      check_cycles("midrst_cycles", 8'd0);
      last_res = 8'd0;
      repeat (3) tick();
      check("midrst_no_result", {31'd0, out_valid}, 32'd0);
      run_pair(8'd6, 8'd4, 8'd2, 3, "p6_4");
      release_result("p6_4");

      // Longest iteration at WIDTH=8; counter reaches all-ones
      run_pair(8'd255, 8'd1, 8'd1, 255, "p255_1");
      release_result("p255_1");

      // Back-to-back pairs with in_valid held high; operands changed while
      // busy must not disturb the first result
      out_ready = 1'b1;
      x_in = 8'd35;
      y_in = 8'd25;
      in_valid = 1'b1;
      tick();
      x_in = 8'd17;
      y_in = 8'd5;
      wait_valid(lat);
      check("b2b_first_latency", lat, 32'd5);
      check("b2b_first_data", {24'd0, out_data}, 32'd5);
      tick();
      check("b2b_bubble_ready", {31'd0, in_ready}, 32'd1);
      check("b2b_bubble_valid", {31'd0, out_valid}, 32'd0);
      tick();
      check("b2b_second_busy", {31'd0, in_ready}, 32'd0);
      check("b2b_second_retain", {24'd0, out_data}, 32'd5);
      wait_valid(lat);
      check("b2b_second_latency", lat, 32'd7);
      check("b2b_second_data", {24'd0, out_data}, 32'd1);
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      check("b2b_end_ready", {31'd0, in_ready}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/gcd_unit.md
GCD_UNIT -- requirements
Module: gcd_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and result width in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-004 SHALL have port in_valid  input  1  operand pair x_in/y_in offered.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have port x_in  input  WIDTH  first unsigned operand.
REQ-007 SHALL have port y_in  input  WIDTH  second unsigned operand.
REQ-008 SHALL have port out_valid  output  1  out_data holds a finished result.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port out_data  output  WIDTH  gcd(x_in, y_in) of the last accepted pair.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-012 IDLE: in_ready=1, out_valid=0; on in_valid=1 at a rising edge, SHALL load X<=x_in and Y<=y_in and go to CALC.
REQ-013 CALC: in_ready=0, out_valid=0; exactly one step per cycle, evaluated on current X and Y.
REQ-014 Step in CALC: if X==0, result<=Y and go to DONE; else if Y==0 or X==Y, result<=X and go to DONE; else if X<Y, Y<=Y-X; else X<=X-Y.
REQ-015 Comparison and subtraction SHALL be unsigned, WIDTH bits; subtraction is always the larger minus the smaller, so no wrap-around occurs.
REQ-016 Latency: out_valid SHALL rise N+1 cycles after the accepting edge, where N is the number of subtraction steps (N=0 for equal or zero operands).
REQ-017 DONE: out_valid=1, in_ready=0; out_data SHALL hold stable while out_ready=0.
REQ-018 DONE with out_ready=1 at an edge SHALL return to IDLE; in_valid is not sampled in that same cycle (one bubble cycle between results).
REQ-019 in_valid asserted outside IDLE SHALL be ignored; operands are not queued.
REQ-020 gcd(0,0) SHALL produce 0; gcd(0,v) and gcd(v,0) SHALL produce v.
REQ-021 out_data SHALL retain the last result in IDLE and CALC until the next DONE.

Reset
REQ-022 rst=0 at an edge SHALL force IDLE, clear X, Y and out_data to 0, and set out_valid=0; after reset in_ready=1.
REQ-023 Reset during CALC or DONE SHALL abandon the computation and produce no result.

Configuration
REQ-024 With macro GCD_UNIT_CYCLE_COUNT_EN defined, SHALL add port cycles  output  WIDTH, the number of CALC cycles spent on the current or last result, saturating at all-ones.
REQ-025 The counter SHALL clear on acceptance, increment once per CALC cycle, hold in DONE and IDLE, and reset to 0.
REQ-026 Without GCD_UNIT_CYCLE_COUNT_EN, the cycles port and its counter SHALL be absent; all other behaviour is unchanged.

Structure
REQ-027 Package gcd_pkg SHALL hold the state typedef gcd_state_t (IDLE, CALC, DONE) and the localparam for the state encoding width.
REQ-028 The X/Y registers, operand muxes, comparator and both subtractors SHALL sit in one sub-module gcd_dp; the FSM and handshake SHALL stay in gcd_unit.

Verification
REQ-029 x=12, y=8 accepted -> X becomes 4, then Y becomes 4, then DONE; out_valid 3 cycles after acceptance, out_data=4, cycles=3 with the macro.
REQ-030 x=0, y=9 -> out_valid after 1 cycle, out_data=9; x=0, y=0 -> out_data=0 after 1 cycle.
REQ-031 x=21, y=14, out_ready held 0 for 5 cycles in DONE -> out_valid=1 and out_data=7 stable all 5 cycles, in_ready=0; IDLE one cycle after out_ready=1.
REQ-032 rst=0 for one cycle mid-CALC on x=100, y=3 -> next cycle in IDLE, in_ready=1, out_valid=0, out_data=0; a new pair 6,4 then yields 2.
REQ-033 WIDTH=8, x=255, y=1 -> 254 subtraction steps, out_valid 255 cycles after acceptance, out_data=1; with the macro, cycles=255 (saturated value).
REQ-034 Back-to-back pairs with in_valid held high (35,25 then 17,5) -> results 5 then 1 in order; in_valid during CALC/DONE is ignored.
